// File: rtl/serial_operand_tx.sv
// serial_operand_tx
//
// Accepts an operand pair over a valid/ready handshake and streams both operands
// LSB-first to a bit-serial adder. It then waits a bounded time for the adder's
// done strobe and presents the captured parallel sum and flags over a
// valid/ready result handshake. If the peer never answers, the block returns an
// error result instead of hanging.
//
// Parameters
//   W         operand width and frame length in cycles
//   TMO       cycles spent in WAIT without done before the frame is aborted
//
// Ports
//   clk       clock, rising edge
//   rst       synchronous active-high reset
//   op_valid  operand pair offered
//   op_ready  block can accept an operand pair (registered, high only in IDLE)
//   op_a      operand A, captured on handshake
//   op_b      operand B, captured on handshake
//   a, b      serial operand bits to the adder, LSB-first (registered)
//   start     frame-start strobe, coincident with bit 0 (registered)
//   done      result strobe from the adder, honoured only in WAIT
//   sum_in    parallel sum from the adder
//   flags_in  {cout, zero, neg, twos_overflow} from the adder
//   res_valid captured result available (registered)
//   res_ready consumer accepts the result
//   res_sum   captured sum (registered)
//   res_flags captured flags (registered)
//   res_err   result is a timeout abort rather than a peer result (registered)

module serial_operand_tx #(
   parameter int unsigned W   = 6,
   parameter int unsigned TMO = 15
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         op_valid,
   output logic         op_ready,
   input  logic [W-1:0] op_a,
   input  logic [W-1:0] op_b,
   output logic         a,
   output logic         b,
   output logic         start,
   input  logic         done,
   input  logic [W-1:0] sum_in,
   input  logic [3:0]   flags_in,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [W-1:0] res_sum,
   output logic [3:0]   res_flags,
   output logic         res_err
);

   localparam int unsigned BitCntW = (W > 1) ? $clog2(W) : 1;
   localparam int unsigned TmoCntW = (TMO > 1) ? $clog2(TMO) : 1;
   localparam logic [BitCntW-1:0] LastBit = BitCntW'(W - 1);
   localparam logic [TmoCntW-1:0] LastTmo = TmoCntW'(TMO - 1);

   typedef enum logic [1:0] {
      StIdle,
      StSend,
      StWait,
      StResp
   } state_e;

   state_e               state_q, state_d;
   logic [W-1:0]         sh_a_q, sh_a_d;
   logic [W-1:0]         sh_b_q, sh_b_d;
   logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
   logic [TmoCntW-1:0]   tmo_cnt_q, tmo_cnt_d;
   logic                 a_q, a_d;
   logic                 b_q, b_d;
   logic                 start_q, start_d;
   logic                 op_ready_q, op_ready_d;
   logic                 res_valid_q, res_valid_d;
   logic [W-1:0]         res_sum_q, res_sum_d;
   logic [3:0]           res_flags_q, res_flags_d;
   logic                 res_err_q, res_err_d;

   always_comb begin
      state_d     = state_q;
      sh_a_d      = sh_a_q;
      sh_b_d      = sh_b_q;
      bit_cnt_d   = bit_cnt_q;
      tmo_cnt_d   = tmo_cnt_q;
      // Serial outputs idle at zero so the peer carry chain sees zeros between frames.
      a_d         = 1'b0;
      b_d         = 1'b0;
      start_d     = 1'b0;
      res_valid_d = res_valid_q;
      res_sum_d   = res_sum_q;
      res_flags_d = res_flags_q;
      res_err_d   = res_err_q;

      unique case (state_q)
         StIdle: begin
            if (op_valid && op_ready_q) begin
               // Bit 0 goes straight to the output register; the shifters hold the rest.
               state_d   = StSend;
               a_d       = op_a[0];
               b_d       = op_b[0];
               start_d   = 1'b1;
               sh_a_d    = op_a >> 1;
               sh_b_d    = op_b >> 1;
               bit_cnt_d = '0;
            end
         end

         StSend: begin
            // bit_cnt_q names the bit currently on a/b.
            if (bit_cnt_q == LastBit) begin
               state_d   = StWait;
               tmo_cnt_d = '0;
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
               a_d       = sh_a_q[0];
               b_d       = sh_b_q[0];
               sh_a_d    = sh_a_q >> 1;
               sh_b_d    = sh_b_q >> 1;
            end
         end

         StWait: begin
            // A done arriving on the final timeout cycle still wins.
            if (done) begin
               state_d     = StResp;
               res_valid_d = 1'b1;
               res_sum_d   = sum_in;
               res_flags_d = flags_in;
               res_err_d   = 1'b0;
            end else if (tmo_cnt_q == LastTmo) begin
               state_d     = StResp;
               res_valid_d = 1'b1;
               res_sum_d   = '0;
               res_flags_d = '0;
               res_err_d   = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
         end

         StResp: begin
            if (res_ready) begin
               state_d     = StIdle;
               res_valid_d = 1'b0;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase

      // Registered from the next state: ready rises the cycle after RESP is left,
      // so no operand is taken on the same edge the result is consumed.
      op_ready_d = (state_d == StIdle);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         sh_a_q      <= '0;
         sh_b_q      <= '0;
         bit_cnt_q   <= '0;
         tmo_cnt_q   <= '0;
         a_q         <= 1'b0;
         b_q         <= 1'b0;
         start_q     <= 1'b0;
         op_ready_q  <= 1'b0;
         res_valid_q <= 1'b0;
         res_sum_q   <= '0;
         res_flags_q <= '0;
         res_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sh_a_q      <= sh_a_d;
         sh_b_q      <= sh_b_d;
         bit_cnt_q   <= bit_cnt_d;
         tmo_cnt_q   <= tmo_cnt_d;
         a_q         <= a_d;
         b_q         <= b_d;
         start_q     <= start_d;
         op_ready_q  <= op_ready_d;
         res_valid_q <= res_valid_d;
         res_sum_q   <= res_sum_d;
         res_flags_q <= res_flags_d;
         res_err_q   <= res_err_d;
      end
   end

   assign a         = a_q;
   assign b         = b_q;
   assign start     = start_q;
   assign op_ready  = op_ready_q;
   assign res_valid = res_valid_q;
   assign res_sum   = res_sum_q;
   assign res_flags = res_flags_q;
   assign res_err   = res_err_q;

endmodule

// File: tb/tb_serial_operand_tx.sv
// Bench for serial_operand_tx: a bit-serial adder peer is modelled here and chained
// to the DUT; expected results come from plain integer arithmetic on the operands.

module tb_serial_operand_tx;

   localparam int unsigned W   = 6;
   localparam int unsigned TMO = 15;
   localparam int          NB2B = 10;

   logic         clk = 1'b0;
   logic         rst;
   logic         op_valid;
   logic         op_ready;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         a;
   logic         b;
   logic         start;
   logic         done;
   logic [W-1:0] sum_in;
   logic [3:0]   flags_in;
   logic         res_valid;
   logic         res_ready;
   logic [W-1:0] res_sum;
   logic [3:0]   res_flags;
   logic         res_err;

   int n_total = 0;
   int n_pass  = 0;
   int cyc     = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_operand_tx #(
      .W   (W),
      .TMO (TMO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .op_valid  (op_valid),
      .op_ready  (op_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .a         (a),
      .b         (b),
      .start     (start),
      .done      (done),
      .sum_in    (sum_in),
      .flags_in  (flags_in),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_sum   (res_sum),
      .res_flags (res_flags),
      .res_err   (res_err)
   );

   // Bit-serial adder peer: carry chain over the serial bits, done one cycle after bit W-1.
   logic         peer_en    = 1'b1;
   logic         pbusy      = 1'b0;
   logic         pc         = 1'b0;
   logic         peer_done  = 1'b0;
   logic [W-1:0] pacc       = '0;
   logic [W-1:0] peer_sum   = '0;
   logic [3:0]   peer_flags = '0;
   int           pcnt       = 0;
   logic         force_done  = 1'b0;
   logic [W-1:0] force_sum   = '0;
   logic [3:0]   force_flags = '0;

   logic         cin, ps, pco;
   logic [W-1:0] last_sum;
   assign cin      = start ? 1'b0 : pc;
   assign ps       = a ^ b ^ cin;
   assign pco      = (a & b) | (a & cin) | (b & cin);
   assign last_sum = {ps, pacc[W-2:0]};

   always @(posedge clk) begin
      peer_done <= 1'b0;
      if (peer_en && start) begin
         pacc  <= W'(ps);
         pc    <= pco;
         pcnt  <= 1;
         pbusy <= 1'b1;
      end else if (pbusy) begin
         pacc[pcnt] <= ps;
         pc         <= pco;
         pcnt       <= pcnt + 1;
         if (pcnt == W - 1) begin
            pbusy      <= 1'b0;
            peer_done  <= 1'b1;
            peer_sum   <= last_sum;
            peer_flags <= {pco, last_sum == '0, ps, pco ^ pc};
         end
      end
   end

   assign done     = peer_done | force_done;
   assign sum_in   = force_done ? force_sum : peer_sum;
   assign flags_in = force_done ? force_flags : peer_flags;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: W-bit addition with flags derived from unsigned and signed sums.
   task automatic ref_add(input int x, input int y, output logic [W-1:0] s,
                          output logic [3:0] f);
      int m, t, r, sx, sy, st;
      m  = 1 << W;
      t  = x + y;
      r  = t % m;
      sx = (x >= m / 2) ? x - m : x;
      sy = (y >= m / 2) ? y - m : y;
      st = sx + sy;
      s  = W'(r);
      f  = {t >= m, r == 0, r >= m / 2, (st >= m / 2) || (st < -(m / 2))};
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] xa, xb, es;
      logic [3:0]   ef;
      int           n, seen, stall, prev_done_cyc, prev_start_cyc;
      int           va[NB2B];
      int           vb[NB2B];

      rst       = 1'b1;
      op_valid  = 1'b0;
      op_a      = '0;
      op_b      = '0;
      res_ready = 1'b0;

      // Reset state
      repeat (3) tick();
      chk("rst_op_ready", op_ready, 0);
      chk("rst_abs", {a, b, start}, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_err", res_err, 0);
      chk("rst_res_sum", res_sum, 0);
      chk("rst_res_flags", res_flags, 0);
      rst = 1'b0;
      tick();
      chk("op_ready_after_rst", op_ready, 1);

      // done while IDLE is ignored
      force_done  = 1'b1;
      force_sum   = 6'h2a;
      force_flags = 4'hf;
      tick();
      force_done = 1'b0;
      chk("idle_done_res_valid", res_valid, 0);
      chk("idle_done_op_ready", op_ready, 1);

      // Directed frame 5 + 3
      xa = 6'b000101;
      xb = 6'b000011;
      op_a = xa;
      op_b = xb;
      op_valid = 1'b1;
      tick();
      op_valid = 1'b0;
      chk("f0_start", start, 1);
      chk("f0_a0", a, xa[0]);
      chk("f0_b0", b, xb[0]);
      chk("f0_op_ready", op_ready, 0);
      for (int i = 1; i < W; i++) begin
         tick();
         chk("f0_a_bit", a, xa[i]);
         chk("f0_b_bit", b, xb[i]);
         chk("f0_start_low", start, 0);
      end
      tick();
      chk("f0_done_cycle", done, 1);
      chk("f0_no_valid_yet", res_valid, 0);
      chk("f0_abs_idle", {a, b, start}, 0);
      tick();
      chk("f0_res_valid", res_valid, 1);
      chk("f0_res_sum", res_sum, 8);
      chk("f0_res_flags", res_flags, 0);
      chk("f0_res_err", res_err, 0);

      // Result held while res_ready = 0; a stray done in RESP must not disturb it
      force_sum   = 6'h3f;
      force_flags = 4'hf;
      for (int i = 0; i < 5; i++) begin
         force_done = (i == 1);
         tick();
         chk("hold_res_valid", res_valid, 1);
         chk("hold_res_sum", res_sum, 8);
         chk("hold_res_flags", res_flags, 0);
         chk("hold_op_ready", op_ready, 0);
         chk("hold_abs", {a, b, start}, 0);
      end
      force_done = 1'b0;
      res_ready  = 1'b1;
      tick();
      chk("release_res_valid", res_valid, 0);
      chk("release_op_ready", op_ready, 1);
      res_ready = 1'b0;

      // Timeout: peer silent
      peer_en  = 1'b0;
      op_a     = W'($urandom);
      op_b     = W'($urandom);
      op_valid = 1'b1;
      tick();
      op_valid = 1'b0;
      n = 1;
      while (!res_valid && n < 100) begin
         tick();
         n++;
      end
      chk("tmo_latency", n, W + 1 + TMO);
      chk("tmo_res_err", res_err, 1);
      chk("tmo_res_sum", res_sum, 0);
      chk("tmo_res_flags", res_flags, 0);
      res_ready = 1'b1;
      tick();
      chk("tmo_release", res_valid, 0);
      res_ready = 1'b0;
      peer_en   = 1'b1;
      tick();

      // Reset during the third bit of SEND
      xa = W'($urandom);
      xb = W'($urandom);
      op_a = xa;
      op_b = xb;
      op_valid = 1'b1;
      tick();
      op_valid = 1'b0;
      tick();
      tick();
      chk("rst_mid_a2", a, xa[2]);
      rst = 1'b1;
      tick();
      chk("rst_mid_abs", {a, b, start}, 0);
      chk("rst_mid_op_ready", op_ready, 0);
      rst = 1'b0;
      tick();
      chk("rst_mid_ready_after", op_ready, 1);
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (res_valid) seen++;
      end
      chk("rst_mid_no_result", seen, 0);

      // Back-to-back frames chained to the peer; the first two are 5+3 and 31+31
      va[0] = 5;
      vb[0] = 3;
      va[1] = 31;
      vb[1] = 31;
      for (int f = 2; f < NB2B; f++) begin
         va[f] = $urandom_range(0, (1 << W) - 1);
         vb[f] = $urandom_range(0, (1 << W) - 1);
      end
      prev_done_cyc  = -100;
      prev_start_cyc = -100;
      res_ready = 1'b1;
      for (int f = 0; f < NB2B; f++) begin
         xa = W'(va[f]);
         xb = W'(vb[f]);
         op_a = xa;
         op_b = xb;
         op_valid = 1'b1;
         n = 0;
         while (!op_ready && n < 50) begin
            tick();
            n++;
         end
         chk("b2b_ready_wait", op_ready, 1);
         tick();
         // Keep offering the next pair while busy; it must wait for IDLE
         if (f + 1 < NB2B) begin
            op_a = W'(va[f+1]);
            op_b = W'(vb[f+1]);
         end else begin
            op_valid = 1'b0;
         end
         chk("b2b_start", start, 1);
         chk("b2b_a0", a, xa[0]);
         chk("b2b_b0", b, xb[0]);
         chk("b2b_op_ready_low", op_ready, 0);
         if (f > 0) begin
            chk("b2b_gap_after_done", (cyc - prev_done_cyc) >= 2, 1);
            chk("b2b_period", (cyc - prev_start_cyc) >= W + 3, 1);
         end
         prev_start_cyc = cyc;
         for (int i = 1; i < W; i++) begin
            tick();
            chk("b2b_a_bit", a, xa[i]);
            chk("b2b_b_bit", b, xb[i]);
         end
         n = 0;
         while (!res_valid && n < 50) begin
            tick();
            n++;
            if (done) prev_done_cyc = cyc;
         end
         chk("b2b_latency", n, 2);
         ref_add(va[f], vb[f], es, ef);
         chk("b2b_res_sum", res_sum, es);
         chk("b2b_res_flags", res_flags, ef);
         chk("b2b_res_err", res_err, 0);
         stall = (f >= 2) ? $urandom_range(0, 3) : 0;
         if (stall > 0) begin
            res_ready = 1'b0;
            for (int i = 0; i < stall; i++) begin
               tick();
               chk("b2b_stall_valid", res_valid, 1);
               chk("b2b_stall_sum", res_sum, es);
            end
            res_ready = 1'b1;
         end
         tick();
         chk("b2b_res_drop", res_valid, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/serial_operand_tx.md
SERIAL_OPERAND_TX -- requirements
Module: serial_operand_tx

Interface
REQ-001 The module SHALL have parameter W, default 6: operand width in bits, and the frame length in cycles.
REQ-002 The module SHALL have parameter TMO, default 15: the number of cycles to wait for peer done after the last bit before it aborts.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port op_valid, input, 1 bit: an operand pair is offered.
REQ-006 The module SHALL have port op_ready, output, 1 bit: the block accepts an operand pair.
REQ-007 The module SHALL have port op_a, input, W bits: operand A, captured on handshake.
REQ-008 The module SHALL have port op_b, input, W bits: operand B, captured on handshake.
REQ-009 The module SHALL have port a, output, 1 bit: serial operand A bit to the serial adder, LSB-first.
REQ-010 The module SHALL have port b, output, 1 bit: serial operand B bit to the serial adder, LSB-first.
REQ-011 The module SHALL have port start, output, 1 bit: frame-start strobe to the serial adder.
REQ-012 The module SHALL have port done, input, 1 bit: result-valid strobe from the serial adder.
REQ-013 The module SHALL have port sum_in, input, W bits: parallel sum from the serial adder.
REQ-014 The module SHALL have port flags_in, input, 4 bits: {cout, zero, neg, twos_overflow} from the serial adder.
REQ-015 The module SHALL have port res_valid, output, 1 bit: a captured result is available.
REQ-016 The module SHALL have port res_ready, input, 1 bit: the consumer accepts the result.
REQ-017 The module SHALL have port res_sum, output, W bits: the captured sum.
REQ-018 The module SHALL have port res_flags, output, 4 bits: the captured flags.
REQ-019 The module SHALL have port res_err, output, 1 bit: the result is a timeout abort, not a peer result.

Function
REQ-020 The FSM SHALL have exactly the states IDLE, SEND, WAIT, RESP.
REQ-021 a, b, start, op_ready, res_valid, res_sum, res_flags and res_err SHALL all be registered outputs.
REQ-022 op_ready SHALL be 1 only in IDLE.
REQ-023 Handshake: when op_valid & op_ready are both 1 at edge k, op_a and op_b SHALL be latched into shift registers and the FSM SHALL go IDLE->SEND.
REQ-024 In SEND, cycle k+1+i (i = 0..W-1) SHALL drive a = op_a[i] and b = op_b[i].
REQ-025 start SHALL be 1 only in cycle k+1, coincident with bit 0.
REQ-026 A bit counter SHALL count 0..W-1; after bit W-1 the FSM SHALL go SEND->WAIT.
REQ-027 Whenever not in SEND, a, b and start SHALL be 0, so the peer carry chain sees zeros between frames.
REQ-028 WAIT SHALL start a timeout counter at 0; done sampled 1 SHALL capture sum_in and flags_in into res_sum and res_flags, set res_err = 0, and go WAIT->RESP.
REQ-029 The nominal peer response is done at cycle k+W+1, so res_valid SHALL rise at cycle k+W+2.
REQ-030 If TMO cycles pass in WAIT without done, the FSM SHALL go to RESP with res_sum = 0, res_flags = 0 and res_err = 1.
REQ-031 RESP SHALL hold res_valid = 1 and keep the result stable until res_ready = 1.
REQ-032 On the edge where res_valid & res_ready, the FSM SHALL go RESP->IDLE and res_valid SHALL drop.
REQ-033 An operand SHALL NOT be accepted in that same cycle, so frames are separated by at least one idle cycle plus the peer done cycle; the peer never sees start during its done state.
REQ-034 done received while in IDLE, SEND or RESP SHALL be ignored.
REQ-035 op_valid while not in IDLE SHALL be ignored; the operand is not dropped, because op_ready = 0.
REQ-036 The block SHALL have no arithmetic; width is fixed to W with no sign extension.
REQ-037 Throughput SHALL be at most one operation per W+3 cycles, with res_ready held at 1.

Reset
REQ-038 While rst = 1 at a clock edge, state SHALL be IDLE and counters 0.
REQ-039 During reset, a, b, start, res_valid and res_err SHALL be 0, res_sum and res_flags SHALL be 0, and op_ready SHALL be 0.
REQ-040 op_ready SHALL be 1 from the first cycle after rst deasserts.
REQ-041 Reset asserted mid-SEND, mid-WAIT or in RESP SHALL abort immediately, discarding the frame and result, and the next cycle's a, b and start SHALL be 0.

Verification
REQ-042 A bench SHALL cover: W=6, op_a=6'b000101, op_b=6'b000011, handshake at edge k -> start=1 with a=1, b=1 at k+1; bit stream a=1,0,1,0,0,0 and b=1,1,0,0,0,0; start=0 for k+2..k+6.
REQ-043 A bench SHALL cover: model peer drives done with sum_in=6'b001000, flags_in=4'b0000 at cycle k+7 -> res_valid=1 at k+8, res_sum=8, res_err=0.
REQ-044 A bench SHALL cover: res_ready held 0 for 5 cycles -> res_valid stays 1, result stable, op_ready=0, a=b=start=0.
REQ-045 A bench SHALL cover: peer never asserts done -> after TMO=15 WAIT cycles, res_valid=1, res_err=1, res_sum=0.
REQ-046 A bench SHALL cover: rst pulsed on the 3rd bit of SEND -> next cycle a=b=start=0, op_ready=1 after release, and no res_valid follows.
REQ-047 A bench SHALL cover: back-to-back op_valid with res_ready=1, chained to the real serial adder -> the second start occurs no earlier than 2 cycles after the first done, and both sums are correct (5+3=8, 31+31=62).
